demux_frame_decoder: RTL and testbench
======================================

DEMUX_FRAME_DECODER -- requirements
Module: demux_frame_decoder

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles a decoded bit is presented to the 1x8 demux (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port ser_in, input, 1 bit, the serial frame bit, sampled only when ser_valid=1.
REQ-005 The block SHALL have port ser_valid, input, 1 bit, the bit strobe; one frame bit is accepted per cycle with ser_valid=1.
REQ-006 The block SHALL have port sel, output, 3 bits, the demux channel select.
REQ-007 The block SHALL have port dmx_in, output, 1 bit, the demux data input.
REQ-008 The block SHALL have port dmx_valid, output, 1 bit, which is high while sel/dmx_in carry a decoded frame.
REQ-009 The block SHALL have port busy, output, 1 bit, which is high in every state except IDLE.
REQ-010 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse marking a completed frame.
REQ-011 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse marking a bad stop bit.

Function
REQ-012 The frame SHALL be 6 accepted bits in this order: start (1), addr[2], addr[1], addr[0], data, stop (0).
REQ-013 The FSM SHALL have states IDLE, ADDR, DATA, STOP and DRIVE, all registered.
REQ-014 In IDLE, an accepted bit of 1 SHALL move the FSM to ADDR; an accepted 0 or a cycle with ser_valid=0 SHALL keep it in IDLE.
REQ-015 In ADDR, the block SHALL shift 3 accepted bits MSB-first into an address register using a 2-bit bit counter, then move to DATA.
REQ-016 In DATA, the block SHALL latch one accepted bit into a data register, then move to STOP.
REQ-017 In STOP, an accepted 0 SHALL move the FSM to DRIVE; an accepted 1 SHALL pulse frame_err for exactly 1 cycle, return to IDLE, and leave sel and dmx_in unchanged.
REQ-018 In ADDR, DATA and STOP, cycles with ser_valid=0 SHALL hold state and counters, with no timeout.
REQ-019 Latency: if the stop bit is accepted at edge k, then dmx_valid=1, sel=addr and dmx_in=data SHALL hold from edge k+1 for exactly HOLD_CYCLES cycles, counted by an 8-bit down-counter.
REQ-020 frame_done SHALL be 1 only in the last DRIVE cycle; the FSM SHALL be in IDLE at the following edge.
REQ-021 With HOLD_CYCLES=1, dmx_valid and frame_done SHALL be high in the same single cycle.
REQ-022 ser_valid SHALL be ignored in DRIVE; bits offered during DRIVE are dropped and are not counted as start bits.
REQ-023 Outside DRIVE, dmx_in SHALL be 0 and dmx_valid SHALL be 0, while sel SHALL hold the last driven address, so demux outputs are all-zero between frames.
REQ-024 An accepted bit in the IDLE cycle immediately after DRIVE SHALL be decoded normally, so back-to-back frames are legal.
REQ-025 frame_done and frame_err SHALL never be high in the same cycle.

Reset
REQ-026 When rst=1 at a rising edge, the FSM SHALL go to IDLE, and the counters, address and data registers SHALL clear.
REQ-027 Outputs after reset SHALL be: sel=000, dmx_in=0, dmx_valid=0, busy=0, frame_done=0, frame_err=0.
REQ-028 Reset SHALL take priority over ser_valid in the same cycle.
REQ-029 Reset asserted mid-frame or mid-DRIVE SHALL abort the frame with no frame_done or frame_err pulse.

Verification
REQ-030 With HOLD_CYCLES=4, bits 1,1,0,1,1,0 on consecutive ser_valid cycles SHALL give sel=101, dmx_in=1 and dmx_valid=1 for 4 cycles starting 1 cycle after the stop bit, with frame_done in the 4th cycle, busy=0 afterwards, and dmx_in=0.
REQ-031 Bits 1,0,1,0,0,0 SHALL give sel=010, dmx_in=0 and dmx_valid=1 for 4 cycles, then sel stays 010.
REQ-032 Bits 1,1,1,1,1,1 (bad stop) SHALL give frame_err=1 for 1 cycle, no dmx_valid, and sel unchanged from its prior value.
REQ-033 Frame 1,0,1,1,1,0 with 3 idle (ser_valid=0) cycles inserted between the address bits SHALL decode to sel=011, dmx_in=1, with the same latency measured from the stop bit.
REQ-034 For frame 1,1,1,1,1,0, extra 1-bits offered during DRIVE SHALL be ignored; a second frame 1,0,0,0,1,0 starting on the first IDLE cycle SHALL give sel=000, dmx_in=1.
REQ-035 rst=1 after the data bit of a frame, followed by bits 0 then the frame 1,0,0,1,1,0, SHALL give no pulse for the aborted frame and a correct drive of sel=001, dmx_in=1.

Source files
------------

// File: rtl/demux_frame_decoder.sv
// Serial frame decoder feeding a 1x8 demux: receives start/addr[2:0]/data/stop
// frames and presents the decoded address and data bit for HOLD_CYCLES cycles.
module demux_frame_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic [2:0] sel,
    output logic       dmx_in,
    output logic       dmx_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DRIVE = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

    state_t     state_r;
    logic [1:0] bit_cnt_r;
    logic [2:0] addr_r;
    logic       data_r;
    logic [7:0] hold_cnt_r;
    logic [2:0] sel_r;
    logic       dmx_in_r;
    logic       dmx_valid_r;
    logic       busy_r;
    logic       frame_done_r;
    logic       frame_err_r;

    // Frame FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 2'd0;
            addr_r       <= 3'd0;
            data_r       <= 1'b0;
            hold_cnt_r   <= 8'd0;
            sel_r        <= 3'd0;
            dmx_in_r     <= 1'b0;
            dmx_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ser_valid && ser_in) begin
                        state_r   <= ST_ADDR;
                        bit_cnt_r <= 2'd0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (ser_valid) begin
                        addr_r <= {addr_r[1:0], ser_in};
                        if (bit_cnt_r == 2'd2) begin
                            bit_cnt_r <= 2'd0;
                            state_r   <= ST_DATA;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (ser_valid) begin
                        data_r  <= ser_in;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (ser_valid) begin
                        if (!ser_in) begin
                            state_r      <= ST_DRIVE;
                            sel_r        <= addr_r;
                            dmx_in_r     <= data_r;
                            dmx_valid_r  <= 1'b1;
                            hold_cnt_r   <= HOLD_INIT;
                            frame_done_r <= (HOLD_INIT == 8'd1);
                        end else begin
                            // Bad stop bit: sel keeps the previously driven address.
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    // Serial input is deliberately ignored while driving.
                    if (hold_cnt_r <= 8'd1) begin
                        state_r     <= ST_IDLE;
                        hold_cnt_r  <= 8'd0;
                        dmx_in_r    <= 1'b0;
                        dmx_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        hold_cnt_r   <= hold_cnt_r - 8'd1;
                        frame_done_r <= (hold_cnt_r == 8'd2);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bit_cnt_r   <= 2'd0;
                    hold_cnt_r  <= 8'd0;
                    dmx_in_r    <= 1'b0;
                    dmx_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = sel_r;
    assign dmx_in     = dmx_in_r;
    assign dmx_valid  = dmx_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_demux_frame_decoder.sv
// Directed bench for demux_frame_decoder: per-cycle expected outputs are queued
// as stimulus is driven and compared one cycle later.
module tb_demux_frame_decoder;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic [2:0] sel;
    logic       dmx_in;
    logic       dmx_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    typedef struct packed {
        logic [2:0] sel;
        logic       din;
        logic       val;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    obs_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] cur_sel = 3'd0;

    demux_frame_decoder #(.HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .sel        (sel),
        .dmx_in     (dmx_in),
        .dmx_valid  (dmx_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [2:0] s, input logic d, input logic v,
                                input logic b, input logic dn, input logic er);
        obs_t o;
        o.sel  = s;
        o.din  = d;
        o.val  = v;
        o.busy = b;
        o.done = dn;
        o.err  = er;
        return o;
    endfunction

    task automatic step(input string tag, input logic r, input logic v, input logic b,
                        input obs_t e);
        obs_t got;
        obs_t want;
        rst       = r;
        ser_valid = v;
        ser_in    = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = mk(sel, dmx_in, dmx_valid, busy, frame_done, frame_err);
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got sel=%b din=%b val=%b busy=%b done=%b err=%b, expected sel=%b din=%b val=%b busy=%b done=%b err=%b",
                   tag, got.sel, got.din, got.val, got.busy, got.done, got.err,
                   want.sel, want.din, want.val, want.busy, want.done, want.err);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, mk(cur_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Sends one frame; gap idle cycles follow addr[2]; dv/db are offered during DRIVE.
    task automatic frame(input string tag, input logic [2:0] a, input logic d,
                         input logic stopb, input int gap, input logic dv, input logic db);
        obs_t bsy;
        bsy = mk(cur_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step({tag, "_start"}, 1'b0, 1'b1, 1'b1, bsy);
        for (int i = 2; i >= 0; i--) begin
            step({tag, "_addr"}, 1'b0, 1'b1, a[i], bsy);
            if (i == 2) begin
                for (int g = 0; g < gap; g++) step({tag, "_gap"}, 1'b0, 1'b0, 1'b1, bsy);
            end
        end
        step({tag, "_data"}, 1'b0, 1'b1, d, bsy);
        if (stopb) begin
            step({tag, "_err"}, 1'b0, 1'b1, 1'b1, mk(cur_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            step({tag, "_drive"}, 1'b0, 1'b1, 1'b0, mk(a, d, 1'b1, 1'b1, 1'(H == 1), 1'b0));
            for (int i = 1; i <= H; i++) begin
                step({tag, "_hold"}, 1'b0, dv, db,
                     mk(a, (i < H) ? d : 1'b0, 1'(i < H), 1'(i < H), 1'(i == H - 1), 1'b0));
            end
            cur_sel = a;
        end
    endtask

    initial begin
        obs_t bsy;
        // Reset wins over an offered start bit.
        step("reset", 1'b1, 1'b1, 1'b1, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cur_sel = 3'd0;
        idle("post_reset");
        step("idle_zero_bit", 1'b0, 1'b1, 1'b0, mk(cur_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        frame("f101", 3'b101, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle("f101_after");
        frame("f010", 3'b010, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        idle("f010_after");
        frame("badstop", 3'b111, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle("badstop_after");
        frame("gap011", 3'b011, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        idle("gap011_after");

        // Ones offered during DRIVE are dropped; next frame starts on first IDLE cycle.
        frame("f111", 3'b111, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        frame("b2b000", 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle("b2b_after");

        // Abort after the data bit.
        bsy = mk(cur_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("abort_start", 1'b0, 1'b1, 1'b1, bsy);
        step("abort_a2", 1'b0, 1'b1, 1'b1, bsy);
        step("abort_a1", 1'b0, 1'b1, 1'b1, bsy);
        step("abort_a0", 1'b0, 1'b1, 1'b0, bsy);
        step("abort_data", 1'b0, 1'b1, 1'b1, bsy);
        step("abort_rst", 1'b1, 1'b1, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cur_sel = 3'd0;
        step("abort_zero", 1'b0, 1'b1, 1'b0, mk(cur_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        frame("f001", 3'b001, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle("f001_after");

        // Abort in the middle of DRIVE.
        bsy = mk(cur_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_start", 1'b0, 1'b1, 1'b1, bsy);
        step("mid_a2", 1'b0, 1'b1, 1'b1, bsy);
        step("mid_a1", 1'b0, 1'b1, 1'b1, bsy);
        step("mid_a0", 1'b0, 1'b1, 1'b0, bsy);
        step("mid_data", 1'b0, 1'b1, 1'b1, bsy);
        step("mid_stop", 1'b0, 1'b1, 1'b0, mk(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step("mid_hold", 1'b0, 1'b0, 1'b0, mk(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        step("mid_rst", 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cur_sel = 3'd0;
        idle("mid_after1");
        idle("mid_after2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
